// File: rtl/spi_memory_burst_sequencer.sv
// spi_memory_burst_sequencer
//
// Turns one SPI burst command into a series of single-message accesses on the
// memory manager bus. A command (direction, memory code, start address,
// message count minus one) is latched in IDLE. The sequencer then asks the core
// to pause and waits for the grant. After that it issues one program or read
// strobe per message and auto-increments the message address, wrapping
// modulo 2^START_ADDRESS_BIT_WIDTH. Write data arrives over a valid/ready
// handshake. Read data leaves over a valid/ready handshake.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   cmd_valid / cmd_ready       burst command handshake (ready only in IDLE)
//   cmd_is_write, cmd_code,
//   cmd_start_address,
//   cmd_length                  burst description (length = count - 1)
//   abort                       terminate the current burst early
//   core_pause_request          asks the core to stop using the memories
//   core_paused                 core grant
//   wr_valid/wr_ready/wr_data   write message stream in
//   rd_valid/rd_ready/rd_data   read message stream out
//   program_memory_new          single-cycle write strobe to memory managers
//   read_memory_sync            single-cycle read strobe to memory managers
//   memory_code, spi_address,
//   spi_data_in                 code/address/data presented to the managers
//   spi_data_out                read data from the selected manager
//   busy                        high whenever not IDLE
//   done                        one-cycle pulse as the burst ends

module spi_memory_burst_sequencer #(
  parameter int START_ADDRESS_BIT_WIDTH = 14,
  parameter int MESSAGE_BIT_WIDTH       = 32,
  parameter int LENGTH_BIT_WIDTH        = 14,
  parameter int CODE_BIT_WIDTH          = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               cmd_valid,
  output logic                               cmd_ready,
  input  logic                               cmd_is_write,
  input  logic [CODE_BIT_WIDTH-1:0]          cmd_code,
  input  logic [START_ADDRESS_BIT_WIDTH-1:0] cmd_start_address,
  input  logic [LENGTH_BIT_WIDTH-1:0]        cmd_length,
  input  logic                               abort,
  output logic                               core_pause_request,
  input  logic                               core_paused,
  input  logic                               wr_valid,
  output logic                               wr_ready,
  input  logic [MESSAGE_BIT_WIDTH-1:0]       wr_data,
  output logic                               rd_valid,
  input  logic                               rd_ready,
  output logic [MESSAGE_BIT_WIDTH-1:0]       rd_data,
  output logic                               program_memory_new,
  output logic                               read_memory_sync,
  output logic [CODE_BIT_WIDTH-1:0]          memory_code,
  output logic [START_ADDRESS_BIT_WIDTH-1:0] spi_address,
  output logic [MESSAGE_BIT_WIDTH-1:0]       spi_data_in,
  input  logic [MESSAGE_BIT_WIDTH-1:0]       spi_data_out,
  output logic                               busy,
  output logic                               done
);

  typedef enum logic [2:0] {
    IDLE,
    PAUSE_WAIT,
    WR_WAIT,
    WR_ISSUE,
    RD_ISSUE,
    RD_CAPTURE,
    RD_HOLD,
    RELEASE
  } state_t;

  state_t                               state_q, state_d;
  logic                                 is_write_q, is_write_d;
  logic [CODE_BIT_WIDTH-1:0]            memory_code_q, memory_code_d;
  logic [START_ADDRESS_BIT_WIDTH-1:0]   spi_address_q, spi_address_d;
  logic [LENGTH_BIT_WIDTH-1:0]          remaining_q, remaining_d;
  logic [MESSAGE_BIT_WIDTH-1:0]         spi_data_in_q, spi_data_in_d;
  logic [MESSAGE_BIT_WIDTH-1:0]         rd_data_q, rd_data_d;

  // State and datapath registers. Reset returns to IDLE with every register
  // cleared, which also kills any strobe or done pulse of an interrupted burst.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      is_write_q    <= 1'b0;
      memory_code_q <= '0;
      spi_address_q <= '0;
      remaining_q   <= '0;
      spi_data_in_q <= '0;
      rd_data_q     <= '0;
    end else begin
      state_q       <= state_d;
      is_write_q    <= is_write_d;
      memory_code_q <= memory_code_d;
      spi_address_q <= spi_address_d;
      remaining_q   <= remaining_d;
      spi_data_in_q <= spi_data_in_d;
      rd_data_q     <= rd_data_d;
    end
  end

  // Next-state and datapath update. abort jumps to RELEASE from any active
  // state. A strobe already decoded from the current state still goes out,
  // and RELEASE still produces the done pulse.
  always_comb begin
    state_d       = state_q;
    is_write_d    = is_write_q;
    memory_code_d = memory_code_q;
    spi_address_d = spi_address_q;
    remaining_d   = remaining_q;
    spi_data_in_d = spi_data_in_q;
    rd_data_d     = rd_data_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          is_write_d    = cmd_is_write;
          memory_code_d = cmd_code;
          spi_address_d = cmd_start_address;
          remaining_d   = cmd_length;
          state_d       = PAUSE_WAIT;
        end
      end
      PAUSE_WAIT: begin
        if (abort)            state_d = RELEASE;
        else if (core_paused) state_d = is_write_q ? WR_WAIT : RD_ISSUE;
      end
      WR_WAIT: begin
        if (abort) begin
          state_d = RELEASE;
        end else if (wr_valid) begin
          spi_data_in_d = wr_data;
          state_d       = WR_ISSUE;
        end
      end
      WR_ISSUE: begin
        if (abort || remaining_q == '0) begin
          state_d = RELEASE;
        end else begin
          spi_address_d = spi_address_q + START_ADDRESS_BIT_WIDTH'(1);
          remaining_d   = remaining_q - LENGTH_BIT_WIDTH'(1);
          state_d       = WR_WAIT;
        end
      end
      RD_ISSUE: begin
        state_d = abort ? RELEASE : RD_CAPTURE;
      end
      RD_CAPTURE: begin
        // The memory answers one cycle after the read strobe.
        rd_data_d = spi_data_out;
        state_d   = abort ? RELEASE : RD_HOLD;
      end
      RD_HOLD: begin
        if (abort) begin
          state_d = RELEASE;
        end else if (rd_ready) begin
          if (remaining_q == '0) begin
            state_d = RELEASE;
          end else begin
            spi_address_d = spi_address_q + START_ADDRESS_BIT_WIDTH'(1);
            remaining_d   = remaining_q - LENGTH_BIT_WIDTH'(1);
            state_d       = RD_ISSUE;
          end
        end
      end
      RELEASE: begin
        memory_code_d = '0;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Every handshake signal and strobe is decoded from the state register.
  // The pause request spans every non-IDLE state, so it equals busy.
  assign cmd_ready          = (state_q == IDLE);
  assign busy               = (state_q != IDLE);
  assign core_pause_request = busy;
  assign wr_ready           = (state_q == WR_WAIT) && !abort;
  assign rd_valid           = (state_q == RD_HOLD);
  assign program_memory_new = (state_q == WR_ISSUE);
  assign read_memory_sync   = (state_q == RD_ISSUE);
  assign done               = (state_q == RELEASE);
  assign memory_code        = memory_code_q;
  assign spi_address        = spi_address_q;
  assign spi_data_in        = spi_data_in_q;
  assign rd_data            = rd_data_q;

endmodule
